// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad by driving one column low at a time and sensing
// the active-low rows. A press is accepted only after the sensed row bit has
// stayed low for DEBOUNCE_CNT consecutive cycles. It is then reported once on
// key_valid, together with its hex code, and held on key_held until a release
// has been stable for DEBOUNCE_CNT cycles.
//
// Parameters
//   SCAN_DIV      clk cycles per column step (>= 2)
//   DEBOUNCE_CNT  stable cycles needed to accept a press or release (>= 2)
//
// Ports
//   clk        in   block clock, rising edge
//   reset      in   asynchronous active-low reset
//   row[3:0]   in   row sense, active-low, asynchronous to clk
//   col[3:0]   out  column drive, one-cold
//   key_code   out  hex code of the last accepted key
//   key_valid  out  one-cycle pulse per accepted press
//   key_held   out  high while the accepted key remains pressed
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 20000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   // Counters are wide enough to hold their terminal values without wrapping.
   localparam int unsigned STEP_W = $clog2(SCAN_DIV + 1);
   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SCAN_DIV - 1);
   localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(SCAN_DIV);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);
   localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_e;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [3:0]        sync1_q;
   logic [3:0]        rs_q;
   state_e            state_q,     state_d;
   logic [STEP_W-1:0] step_q,      step_d;
   logic [DEB_W-1:0]  deb_q,       deb_d;
   logic [1:0]        col_idx_q,   col_idx_d;
   logic [1:0]        row_idx_q,   row_idx_d;
   logic [3:0]        key_code_q,  key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_held_q,  key_held_d;

   // -------------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------------
   function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'h0;
         4'b11_01: code = 4'hF;
         4'b11_10: code = 4'hE;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // Lowest-index low row wins when several rows are low together.
   function automatic logic [1:0] low_row(input logic [3:0] rs);
      logic [1:0] idx;
      if (!rs[0])      idx = 2'd0;
      else if (!rs[1]) idx = 2'd1;
      else if (!rs[2]) idx = 2'd2;
      else             idx = 2'd3;
      return idx;
   endfunction

   logic              row_bit;
   logic [STEP_W-1:0] step_inc;
   logic [DEB_W-1:0]  deb_inc;

   always_comb begin
      row_bit  = rs_q[row_idx_q];
      step_inc = (step_q == STEP_MAX) ? step_q : step_q + STEP_W'(1);
      deb_inc  = (deb_q == DEB_MAX)   ? deb_q  : deb_q + DEB_W'(1);
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q     <= 4'b1111;
         rs_q        <= 4'b1111;
         state_q     <= ST_SCAN;
         step_q      <= '0;
         deb_q       <= '0;
         col_idx_q   <= '0;
         row_idx_q   <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         sync1_q     <= row;
         rs_q        <= sync1_q;
         state_q     <= state_d;
         step_q      <= step_d;
         deb_q       <= deb_d;
         col_idx_q   <= col_idx_d;
         row_idx_q   <= row_idx_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      deb_d       = deb_q;
      col_idx_d   = col_idx_q;
      row_idx_d   = row_idx_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      unique case (state_q)
         ST_SCAN: begin
            // Rows are only trusted on the last cycle of a step, giving the
            // keypad lines the rest of the step to settle after a column move.
            if (step_q == STEP_LAST) begin
               step_d = '0;
               if (rs_q == 4'b1111) begin
                  col_idx_d = col_idx_q + 2'd1;
               end else begin
                  row_idx_d = low_row(rs_q);
                  deb_d     = '0;
                  state_d   = ST_DEBOUNCE;
               end
            end else begin
               step_d = step_inc;
            end
         end

         ST_DEBOUNCE: begin
            if (!row_bit) begin
               if (deb_q == DEB_LAST) begin
                  key_code_d  = map_key(row_idx_q, col_idx_q);
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  deb_d       = '0;
                  state_d     = ST_HELD;
               end else begin
                  deb_d = deb_inc;
               end
            end else begin
               // Bounce: give up on this column and move on.
               deb_d     = '0;
               step_d    = '0;
               col_idx_d = col_idx_q + 2'd1;
               state_d   = ST_SCAN;
            end
         end

         ST_HELD: begin
            if (row_bit) begin
               deb_d   = '0;
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (row_bit) begin
               if (deb_q == DEB_LAST) begin
                  key_held_d = 1'b0;
                  deb_d      = '0;
                  step_d     = '0;
                  col_idx_d  = col_idx_q + 2'd1;
                  state_d    = ST_SCAN;
               end else begin
                  deb_d = deb_inc;
               end
            end else begin
               deb_d   = '0;
               state_d = ST_HELD;
            end
         end

         default: begin
            state_d = ST_SCAN;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      col             = 4'b1111;
      col[col_idx_q]  = 1'b0;
      key_code        = key_code_q;
      key_valid       = key_valid_q;
      key_held        = key_held_q;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   // key_mat[r][c] = 1 means the key at row r, column c is pressed.
   logic [3:0] key_mat [4];

   int n_checks;
   int n_errors;
   logic [3:0] sb [$];

   keypad_scanner #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a row reads low when a pressed key sits in the driven column.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row[r] = ~|(key_mat[r] & ~col);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] rot(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

   task automatic wait_held(input logic v, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (key_held === v) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_col(input logic [3:0] v, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (col === v) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Output monitor: every key_valid pulse is matched against the scoreboard.
   logic       prev_valid;
   logic [3:0] last_code;

   always @(negedge clk) begin
      if (!reset) begin
         prev_valid <= 1'b0;
         last_code  <= 4'h0;
      end else begin
         if (key_valid === 1'b1) begin
            chk("valid_consec", prev_valid, 0);
            if (sb.size() == 0) chk("valid_unexpected", key_valid, 0);
            else                chk("key_code", key_code, sb.pop_front());
            last_code <= key_code;
         end else if (key_code !== last_code) begin
            chk("code_stable", key_code, last_code);
         end
         prev_valid <= key_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      int         run;
      int         changes;
      int         stay;
      logic [3:0] prev;
      bit         held_ok;

      n_checks = 0;
      n_errors = 0;
      for (int r = 0; r < 4; r++) key_mat[r] = 4'b0000;
      reset = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_col",   col,       4'b1110);
      chk("rst_code",  key_code,  4'h0);
      chk("rst_valid", key_valid, 0);
      chk("rst_held",  key_held,  0);

      // Idle scanning: rotate every SCAN_DIV cycles
      @(negedge clk);
      reset   = 1'b1;
      prev    = col;
      run     = 0;
      changes = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         run++;
         if (col !== prev) begin
            chk("idle_rot",    col, rot(prev));
            chk("idle_period", run, 4);
            changes++;
            prev = col;
            run  = 0;
         end
      end
      chk("idle_changes", changes, 10);

      // Key '6' (row 1, column 2) pressed and held
      key_mat[1][2] = 1'b1;
      sb.push_back(4'h6);
      wait_held(1'b1, 200, ok);
      chk("press6_seen", ok, 1);
      chk("press6_col",  col, 4'b1011);
      chk("press6_code", key_code, 4'h6);
      repeat (30) @(negedge clk);
      chk("hold6_col",  col, 4'b1011);
      chk("hold6_held", key_held, 1);
      chk("hold6_sb",   sb.size(), 0);

      // Release with a 3-cycle glitch
      held_ok = 1'b1;
      key_mat[1][2] = 1'b0;
      repeat (4) begin @(negedge clk); if (key_held !== 1'b1) held_ok = 1'b0; end
      key_mat[1][2] = 1'b1;
      repeat (3) begin @(negedge clk); if (key_held !== 1'b1) held_ok = 1'b0; end
      key_mat[1][2] = 1'b0;
      repeat (8) begin @(negedge clk); if (key_held !== 1'b1) held_ok = 1'b0; end
      chk("glitch_held", held_ok, 1);
      wait_held(1'b0, 40, ok);
      chk("release_seen", ok, 1);
      chk("release_col",  col, 4'b0111);

      // Bounce at column 0: too short to accept
      wait_col(4'b1110, 40, ok);
      chk("bounce_reach", ok, 1);
      key_mat[0][0] = 1'b1;
      stay = 0;
      repeat (5) begin @(negedge clk); if (col === 4'b1110) stay++; end
      key_mat[0][0] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (col !== 4'b1110) break;
         @(negedge clk);
         if (col === 4'b1110) stay++;
      end
      chk("bounce_col",   col, 4'b1101);
      chk("bounce_dwell", stay > 4, 1);
      chk("bounce_held",  key_held, 0);

      // Rows 2 and 3 together at column 3: row 2 wins
      key_mat[2][3] = 1'b1;
      key_mat[3][3] = 1'b1;
      sb.push_back(4'hC);
      wait_held(1'b1, 200, ok);
      chk("prio_seen", ok, 1);
      chk("prio_code", key_code, 4'hC);
      chk("prio_col",  col, 4'b0111);

      // Reset while held
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_col",   col,       4'b1110);
      chk("midrst_held",  key_held,  0);
      chk("midrst_code",  key_code,  4'h0);
      chk("midrst_valid", key_valid, 0);
      key_mat[2][3] = 1'b0;
      key_mat[3][3] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("restart_col0", col, 4'b1110);
      @(negedge clk);
      chk("restart_col1", col, 4'b1101);

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles per column step (minimum 2).
REQ-002 Parameter DEBOUNCE_CNT, default 20000, consecutive stable clk cycles required for press or release acceptance (minimum 2).
REQ-003 clk  input  1  block clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 row  input  4  keypad row sense, active-low (0 = pressed key in driven column), asynchronous to clk.
REQ-006 col  output  4  keypad column drive, one-cold: exactly one bit 0, others 1.
REQ-007 key_code  output  4  hex code of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a new key press is accepted.
REQ-009 key_held  output  1  high while the accepted key remains pressed (until release is accepted).

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rs; the synchronizer adds 2 cycles of latency to every row event.
REQ-011 Key map (row index r, column index c, column c driven low via col[c]): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D, for c = 0..3.
REQ-012 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: step counter counts 0..SCAN_DIV-1; at count SCAN_DIV-1, if rs == 4'b1111, col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wrap) and counter clears.
REQ-014 SCAN: at count SCAN_DIV-1 with any rs bit low, block SHALL latch column index and lowest-index low row (priority r0 > r3), freeze col, clear debounce counter, enter DEBOUNCE.
REQ-015 rs is sampled only at the last cycle of a step; low rows seen earlier in the step are ignored (settling time).
REQ-016 DEBOUNCE: each cycle the latched row bit is low, counter increments; at DEBOUNCE_CNT consecutive low cycles, key_code = mapped code, key_valid = 1 for exactly that one cycle, key_held = 1, enter HELD.
REQ-017 DEBOUNCE: latched row bit high in any cycle -> counter clears, return to SCAN, advance col to next column, no key_valid.
REQ-018 HELD: col stays frozen; first cycle latched row bit reads high -> clear counter, enter RELEASE; other rows ignored (no rollover, no second key).
REQ-019 RELEASE: latched row bit high for DEBOUNCE_CNT consecutive cycles -> key_held = 0, advance col to next column, enter SCAN with step counter 0; bit low in any cycle -> back to HELD, key_held stays 1.
REQ-020 key_code SHALL hold its value until the next accepted press; it never changes outside the key_valid cycle.
REQ-021 key_valid SHALL never assert in two consecutive cycles; the same key held continuously produces exactly one pulse.
REQ-022 Counters SHALL be sized to hold DEBOUNCE_CNT and SCAN_DIV without wrap; counters saturate rather than wrap.

Reset
REQ-023 reset low SHALL immediately force col = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0, state SCAN, all counters and synchronizer flops to idle (synchronizer = 4'b1111).
REQ-024 reset asserted mid-DEBOUNCE/HELD/RELEASE SHALL abort without a key_valid pulse; after deassertion, scanning restarts from column 0.
REQ-025 Reset deassertion is synchronous to clk by the integrating top level; the block has no other reset source.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-026 Idle, row = 1111 for 40 cycles -> col sequence 1110,1101,1011,0111,1110 changing every 4 cycles; key_valid never 1.
REQ-027 Hold row[1] low whenever col = 1011 for 30 cycles -> exactly one key_valid pulse with key_code = 4'h6, key_held = 1, col frozen at 1011.
REQ-028 Bounce: row[0] low at col 1110 for 5 cycles then high -> no key_valid, col advances to 1101, scan resumes.
REQ-029 Release with 3-cycle glitch low after 4 high cycles, then high for 8 cycles -> key_held stays 1 through glitch, drops after the final 8 high cycles, no extra key_valid.
REQ-030 row[2] and row[3] low together at col 0111 -> key_code = 4'hC (row 2 priority); then reset low mid-HELD -> col = 1110, key_held = 0, key_code = 4'h0 immediately.
